// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding, ALU selector codes and size defaults for the ALU op sequencer.
package alu_seq_pkg;

    localparam int ALU_SEQ_WIDTH = 32;
    localparam int ALU_SEQ_REGS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] ALU_OP_AND     = 4'b0000;
    localparam logic [3:0] ALU_OP_OR      = 4'b0001;
    localparam logic [3:0] ALU_OP_XOR     = 4'b0010;
    localparam logic [3:0] ALU_OP_PASSA   = 4'b0011;
    localparam logic [3:0] ALU_OP_ADD     = 4'b0100;
    localparam logic [3:0] ALU_OP_PASSB   = 4'b0101;
    localparam logic [3:0] ALU_OP_SUB     = 4'b0110;
    localparam logic [3:0] ALU_OP_SLT     = 4'b0111;
    localparam logic [3:0] ALU_OP_ILLEGAL = 4'b1000;
    localparam logic [3:0] ALU_OP_SLL     = 4'b1001;
    localparam logic [3:0] ALU_OP_SRL     = 4'b1010;
    localparam logic [3:0] ALU_OP_SRA     = 4'b1011;
    localparam logic [3:0] ALU_OP_NOP     = 4'b1111;

    function automatic logic is_illegal(input logic [3:0] op);
        return op == ALU_OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: register file with two async read ports and two write ports;
// port 0 (sequencer writeback) overrides port 1 (external load) on an address clash.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ALU_SEQ_WIDTH,
    parameter int REGS  = ALU_SEQ_REGS,
    localparam int AW   = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [WIDTH-1:0] wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [WIDTH-1:0] wd1
);

    logic [WIDTH-1:0] mem [REGS];

    assign ra_data = mem[ra_addr];
    assign rb_data = mem[rb_addr];

    // Port 0 is assigned last so its write lands when both hit one address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) mem[i] <= '0;
        end else begin
            if (we1) mem[wa1] <= wd1;
            if (we0) mem[wa0] <= wd0;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: reads operands, drives an external combinational ALU, writes back and returns the result.
// Define ALU_SEQ_BACK2BACK_EN to accept a new request in RESP while the result is taken (1 op / 2 cycles).
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = ALU_SEQ_WIDTH,
    parameter int REGS  = ALU_SEQ_REGS,
    localparam int AW   = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [AW-1:0]    req_ra,
    input  logic [AW-1:0]    req_rb,
    input  logic [AW-1:0]    req_rd,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_illegal,
    output logic [15:0]      op_count
);

    state_t           state, state_nx;
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] ra_data, rb_data;
    logic             accept;

    assign accept = req_valid && req_ready;

    alu_seq_regfile #(.WIDTH(WIDTH), .REGS(REGS)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (req_ra),
        .ra_data (ra_data),
        .rb_addr (req_rb),
        .rb_data (rb_data),
        .we0     (state == ISSUE),
        .wa0     (rd),
        .wd0     (alu_y),
        .we1     (ld_en),
        .wa1     (ld_addr),
        .wd1     (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // RESP only reaches ISSUE directly when the back-to-back accept is enabled.
    always_comb begin
        state_nx = (state == ISSUE) ? RESP :
                   accept ? ISSUE :
                   (state == RESP && !rsp_ready) ? RESP : IDLE;
    end

    always_comb begin
`ifdef ALU_SEQ_BACK2BACK_EN
        req_ready = (state == IDLE) || (state == RESP && rsp_ready);
`else
        req_ready = (state == IDLE);
`endif
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_sel     <= ALU_OP_NOP;
            alu_a       <= '0;
            alu_b       <= '0;
            rd          <= '0;
            rsp_data    <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            op_count    <= '0;
        end else begin
            if (accept) begin
                alu_sel <= req_op;
                alu_a   <= ra_data;
                alu_b   <= rb_data;
                rd      <= req_rd;
            end
            if (state == ISSUE) begin
                rsp_data    <= alu_y;
                rsp_zero    <= alu_zero;
                rsp_illegal <= is_illegal(alu_sel);
            end
            if (state == RESP && rsp_ready) op_count <= op_count + 16'd1;
        end
    end

endmodule
